// File: rtl/bootram.sv
// Dual-port program/data RAM with a byte-stream boot loader. The CPU is held in
// reset until LOAD_WORDS words have arrived.
module bootram #(
    parameter int WIDTH      = 16,
    parameter int AWIDTH     = 13,
    parameter int LOAD_WORDS = 512,
    parameter int RDW_MODE   = 0
) (
    input  logic              clk,
    input  logic              resetq,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_d,
    input  logic              a_wr,
    output logic [WIDTH-1:0]  a_q,
    input  logic [AWIDTH-1:0] b_addr,
    output logic [WIDTH-1:0]  b_q,
    input  logic              ld_restart,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic              cpu_resetq
);

    localparam int NB = WIDTH / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
    localparam logic [AWIDTH-1:0] LAST_WORD = AWIDTH'((LOAD_WORDS > 0) ? LOAD_WORDS - 1 : 0);
    localparam bit NO_LOAD = (LOAD_WORDS == 0);

    // state  | meaning
    // S_LOAD | loader owns the write port, CPU held in reset
    // S_RUN  | port A owns the write port, CPU running
    typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

    state_t state_q, state_d;
    logic [AWIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [BW-1:0]     byte_idx_q, byte_idx_d;
    logic [WIDTH-1:0]  asm_q, asm_d;

    logic [WIDTH-1:0]  mem [2**AWIDTH];
    logic [AWIDTH-1:0] a_addr_q, b_addr_q;
    logic [WIDTH-1:0]  a_old_q, b_old_q;
    logic              a_hold_q, b_hold_q, a_hold_d, b_hold_d;

    logic              ld_accept, ld_we, a_we, we;
    logic [WIDTH-1:0]  ld_word, wdata;
    logic [AWIDTH-1:0] waddr;

    // Bytes enter at the top and shift down, so the first byte lands in [7:0].
    assign ld_word   = (WIDTH'(ld_data) << (WIDTH - 8)) | (asm_q >> 8);
    assign ld_accept = (state_q == S_LOAD) && ld_valid && !ld_restart;
    assign ld_we     = ld_accept && (byte_idx_q == LAST_BYTE);
    assign a_we      = (state_q == S_RUN) && a_wr;
    assign we        = ld_we || a_we;
    assign waddr     = ld_we ? word_cnt_q : a_addr;
    assign wdata     = ld_we ? ld_word : a_d;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= NO_LOAD ? S_RUN : S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // With nothing to load, a restart would otherwise leave the CPU parked forever.
    always_comb begin
        state_d = state_q;
        if (ld_restart) begin
            state_d = NO_LOAD ? S_RUN : S_LOAD;
        end else if (ld_we && (word_cnt_q == LAST_WORD)) begin
            state_d = S_RUN;
        end
    end

    always_comb begin
        ld_ready   = (state_q == S_LOAD);
        cpu_resetq = (state_q == S_RUN);
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        if (ld_restart) begin
            word_cnt_d = '0;
            byte_idx_d = '0;
            asm_d      = '0;
        end else if (ld_accept) begin
            if (byte_idx_q == LAST_BYTE) begin
                byte_idx_d = '0;
                asm_d      = '0;
                word_cnt_d = (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + AWIDTH'(1);
            end else begin
                byte_idx_d = byte_idx_q + BW'(1);
                asm_d      = ld_word;
            end
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
        end
    end

    // Old-data mode: on a same-address collision, show the pre-write word for one cycle.
    assign a_hold_d = (RDW_MODE == 0) && we && (waddr == a_addr);
    assign b_hold_d = (RDW_MODE == 0) && we && (waddr == b_addr);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            a_addr_q <= '0;
            b_addr_q <= '0;
            a_hold_q <= 1'b0;
            b_hold_q <= 1'b0;
        end else begin
            a_addr_q <= a_addr;
            b_addr_q <= b_addr;
            a_hold_q <= a_hold_d;
            b_hold_q <= b_hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        a_old_q <= mem[a_addr];
        b_old_q <= mem[b_addr];
    end

    assign a_q = a_hold_q ? a_old_q : mem[a_addr_q];
    assign b_q = b_hold_q ? b_old_q : mem[b_addr_q];

endmodule

// File: tb/tb_bootram.sv
// Bench for bootram: two 16-bit instances (old/new read-during-write) share stimulus,
// a third 32-bit instance covers wide-word assembly.
module tb_bootram;

    logic        clk = 1'b0;
    logic        resetq;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_d;
    logic        a_wr, ld_restart, ld_valid;
    logic [7:0]  ld_data;
    logic [15:0] a_q0, b_q0, a_q1, b_q1;
    logic        ld_ready0, cpu_resetq0, ld_ready1, cpu_resetq1;

    logic [7:0]  b_addr2;
    logic        ld_valid2;
    logic [7:0]  ld_data2;
    logic [31:0] a_q2, b_q2;
    logic        ld_ready2, cpu_resetq2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          port_b;
        logic [15:0] e0;
        logic [15:0] e1;
    } exp_t;
    exp_t        sbq[$];
    logic [31:0] sbq32[$];

    always #5 clk = ~clk;

    bootram #(.WIDTH(16), .AWIDTH(8), .LOAD_WORDS(2), .RDW_MODE(0)) dut0 (
        .clk(clk), .resetq(resetq), .a_addr(a_addr), .a_d(a_d), .a_wr(a_wr), .a_q(a_q0),
        .b_addr(b_addr), .b_q(b_q0), .ld_restart(ld_restart), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_ready(ld_ready0), .cpu_resetq(cpu_resetq0));

    bootram #(.WIDTH(16), .AWIDTH(8), .LOAD_WORDS(2), .RDW_MODE(1)) dut1 (
        .clk(clk), .resetq(resetq), .a_addr(a_addr), .a_d(a_d), .a_wr(a_wr), .a_q(a_q1),
        .b_addr(b_addr), .b_q(b_q1), .ld_restart(ld_restart), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_ready(ld_ready1), .cpu_resetq(cpu_resetq1));

    bootram #(.WIDTH(32), .AWIDTH(8), .LOAD_WORDS(1), .RDW_MODE(0)) dut2 (
        .clk(clk), .resetq(resetq), .a_addr(8'h00), .a_d(32'h0), .a_wr(1'b0), .a_q(a_q2),
        .b_addr(b_addr2), .b_q(b_q2), .ld_restart(1'b0), .ld_valid(ld_valid2),
        .ld_data(ld_data2), .ld_ready(ld_ready2), .cpu_resetq(cpu_resetq2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a read of addr on both ports, queues the expected words, compares after one edge.
    task automatic rd16(input string nm, input logic [7:0] addr, input logic [15:0] e0,
                        input logic [15:0] e1);
        exp_t        e;
        logic [15:0] act0, act1;
        a_addr = addr;
        b_addr = addr;
        sbq.push_back('{name: {nm, "_a"}, port_b: 1'b0, e0: e0, e1: e1});
        sbq.push_back('{name: {nm, "_b"}, port_b: 1'b1, e0: e0, e1: e1});
        tick();
        while (sbq.size() > 0) begin
            e    = sbq.pop_front();
            act0 = e.port_b ? b_q0 : a_q0;
            act1 = e.port_b ? b_q1 : a_q1;
            checks++;
            if (act0 !== e.e0 || act1 !== e.e1) begin
                errors++;
                $display("FAIL %s: got %h/%h expected %h/%h", e.name, act0, act1, e.e0, e.e1);
            end
        end
    endtask

    task automatic pa_write(input logic [7:0] addr, input logic [15:0] data);
        a_wr   = 1'b1;
        a_addr = addr;
        a_d    = data;
        tick();
        a_wr   = 1'b0;
    endtask

    task automatic pulse_restart();
        ld_restart = 1'b1;
        tick();
        ld_restart = 1'b0;
    endtask

    // Four bytes, byte i = bytes[8i+:8]; checks the CPU is held after byte 3 and released after byte 4.
    task automatic load16(input logic [31:0] bytes, input int maxgap, input string nm);
        int gap;
        for (int i = 0; i < 4; i++) begin
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            ld_valid = 1'b0;
            repeat (gap) tick();
            ld_valid = 1'b1;
            ld_data  = bytes[8*i +: 8];
            tick();
            ld_valid = 1'b0;
            if (i == 2) begin
                checks++;
                if ({cpu_resetq0, ld_ready0, cpu_resetq1, ld_ready1} !== 4'b0101) begin
                    errors++;
                    $display("FAIL %s_held: cpu_resetq/ld_ready got %b%b %b%b expected 01 01",
                             nm, cpu_resetq0, ld_ready0, cpu_resetq1, ld_ready1);
                end
            end
            if (i == 3) begin
                checks++;
                if ({cpu_resetq0, ld_ready0, cpu_resetq1, ld_ready1} !== 4'b1010) begin
                    errors++;
                    $display("FAIL %s_release: cpu_resetq/ld_ready got %b%b %b%b expected 10 10",
                             nm, cpu_resetq0, ld_ready0, cpu_resetq1, ld_ready1);
                end
            end
        end
    endtask

    task automatic test_reset();
        resetq = 1'b0;
        tick();
        checks++;
        if ({cpu_resetq0, ld_ready0, cpu_resetq1, ld_ready1, cpu_resetq2, ld_ready2} !== 6'b010101) begin
            errors++;
            $display("FAIL reset_ctl: got %b%b %b%b %b%b expected 01 01 01",
                     cpu_resetq0, ld_ready0, cpu_resetq1, ld_ready1, cpu_resetq2, ld_ready2);
        end
        resetq = 1'b1;
        tick();
    endtask

    task automatic test_load_b2b();
        load16(32'h5678_1234, 0, "b2b");
        rd16("b2b_w1", 8'd1, 16'h5678, 16'h5678);
        rd16("b2b_w0", 8'd0, 16'h1234, 16'h1234);
    endtask

    task automatic test_rdw();
        pa_write(8'd5, 16'h1111);
        a_wr = 1'b1;
        a_d  = 16'hBEEF;
        rd16("rdw_same", 8'd5, 16'h1111, 16'hBEEF);
        a_wr = 1'b0;
        rd16("rdw_next", 8'd5, 16'hBEEF, 16'hBEEF);
    endtask

    task automatic test_load_gaps();
        pa_write(8'd0, 16'h0000);
        pa_write(8'd1, 16'h0000);
        rd16("gaps_clr", 8'd1, 16'h0000, 16'h0000);
        pulse_restart();
        checks++;
        if ({cpu_resetq0, ld_ready0, cpu_resetq1, ld_ready1} !== 4'b0101) begin
            errors++;
            $display("FAIL restart_run: cpu_resetq/ld_ready got %b%b %b%b expected 01 01",
                     cpu_resetq0, ld_ready0, cpu_resetq1, ld_ready1);
        end
        load16(32'h5678_1234, 5, "gaps");
        rd16("gaps_w0", 8'd0, 16'h1234, 16'h1234);
        rd16("gaps_w1", 8'd1, 16'h5678, 16'h5678);
    endtask

    task automatic test_run_ld_ignored();
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'hFF;
            tick();
        end
        ld_valid = 1'b0;
        checks++;
        if ({cpu_resetq0, ld_ready0} !== 2'b10) begin
            errors++;
            $display("FAIL run_ignore_ctl: got %b%b expected 10", cpu_resetq0, ld_ready0);
        end
        rd16("run_ignore_w0", 8'd0, 16'h1234, 16'h1234);
        rd16("run_ignore_w1", 8'd1, 16'h5678, 16'h5678);
    endtask

    task automatic test_awr_in_load();
        pa_write(8'd3, 16'h3333);
        pulse_restart();
        pa_write(8'd3, 16'hDEAD);
        rd16("load_awr", 8'd3, 16'h3333, 16'h3333);
    endtask

    task automatic test_reset_midload();
        logic [23:0] first = 24'h33_22_11;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = first[8*i +: 8];
            tick();
        end
        ld_valid = 1'b0;
        rd16("midload_partial", 8'd0, 16'h2211, 16'h2211);
        resetq = 1'b0;
        #2;
        checks++;
        if ({cpu_resetq0, ld_ready0} !== 2'b01) begin
            errors++;
            $display("FAIL midload_reset_ctl: got %b%b expected 01", cpu_resetq0, ld_ready0);
        end
        tick();
        resetq = 1'b1;
        load16(32'hDDCC_BBAA, 2, "midload");
        rd16("midload_w0", 8'd0, 16'hBBAA, 16'hBBAA);
        rd16("midload_w1", 8'd1, 16'hDDCC, 16'hDDCC);
    endtask

    task automatic test_restart_drop();
        logic [31:0] bytes = 32'h04_03_02_01;
        pa_write(8'd0, 16'h0F0F);
        pa_write(8'd1, 16'h0E0E);
        pulse_restart();
        checks++;
        if ({cpu_resetq0, ld_ready0, cpu_resetq1, ld_ready1} !== 4'b0101) begin
            errors++;
            $display("FAIL drop_restart_ctl: got %b%b %b%b expected 01 01",
                     cpu_resetq0, ld_ready0, cpu_resetq1, ld_ready1);
        end
        for (int i = 0; i < 4; i++) begin
            ld_valid   = 1'b1;
            ld_data    = bytes[8*i +: 8];
            ld_restart = (i == 3);
            tick();
        end
        ld_valid   = 1'b0;
        ld_restart = 1'b0;
        checks++;
        if ({cpu_resetq0, ld_ready0} !== 2'b01) begin
            errors++;
            $display("FAIL drop_still_loading: got %b%b expected 01", cpu_resetq0, ld_ready0);
        end
        rd16("drop_w0", 8'd0, 16'h0201, 16'h0201);
        rd16("drop_w1", 8'd1, 16'h0E0E, 16'h0E0E);
        load16(32'h0807_0605, 0, "reload");
        rd16("reload_w0", 8'd0, 16'h0605, 16'h0605);
        rd16("reload_w1", 8'd1, 16'h0807, 16'h0807);
    endtask

    task automatic test_w32();
        logic [31:0] bytes = 32'h04_03_02_01;
        logic [31:0] e;
        b_addr2 = 8'd0;
        for (int i = 0; i < 4; i++) begin
            ld_valid2 = 1'b1;
            ld_data2  = bytes[8*i +: 8];
            tick();
            if (i == 2) begin
                checks++;
                if ({cpu_resetq2, ld_ready2} !== 2'b01) begin
                    errors++;
                    $display("FAIL w32_held: got %b%b expected 01", cpu_resetq2, ld_ready2);
                end
            end
        end
        ld_valid2 = 1'b0;
        checks++;
        if ({cpu_resetq2, ld_ready2} !== 2'b10) begin
            errors++;
            $display("FAIL w32_release: got %b%b expected 10", cpu_resetq2, ld_ready2);
        end
        sbq32.push_back(32'h0403_0201);
        tick();
        e = sbq32.pop_front();
        checks++;
        if (b_q2 !== e || a_q2 !== e) begin
            errors++;
            $display("FAIL w32_word: got b=%h a=%h expected %h", b_q2, a_q2, e);
        end
    endtask

    initial begin
        resetq     = 1'b0;
        a_addr     = '0;
        b_addr     = '0;
        a_d        = '0;
        a_wr       = 1'b0;
        ld_restart = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        b_addr2    = '0;
        ld_valid2  = 1'b0;
        ld_data2   = '0;
        test_reset();
        test_load_b2b();
        test_rdw();
        test_load_gaps();
        test_run_ld_ignored();
        test_awr_in_load();
        test_reset_midload();
        test_restart_drop();
        test_w32();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
